// File: rtl/center_light.sv
// rtl/center_light.sv - one tug-of-war playfield light; lit position marks the rope centre.
// Optional CENTER_LIGHT_SYNC_EN adds 2-flop synchronizers and rising-edge detectors on L and R.
module center_light #(
   parameter logic IS_CENTER = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic L,
   input  logic R,
   input  logic NL,
   input  logic NR,
   output logic lightOn
);

   typedef enum logic {
      OFF = 1'b0,
      ON  = 1'b1
   } state_t;

   localparam state_t RST_STATE = IS_CENTER ? ON : OFF;

   state_t state;
   logic   l_press;
   logic   r_press;
   logic   pull_in;
   logic   push_out;

`ifdef CENTER_LIGHT_SYNC_EN
   logic l_s1, l_s2, l_s3;
   logic r_s1, r_s2, r_s3;

   // s1/s2 synchronize, s3 remembers the previous level so a held button yields one press
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         l_s1 <= 1'b0;
         l_s2 <= 1'b0;
         l_s3 <= 1'b0;
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         l_s1 <= L;
         l_s2 <= l_s1;
         l_s3 <= l_s2;
         r_s1 <= R;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign l_press = l_s2 & ~l_s3;
   assign r_press = r_s2 & ~r_s3;
`else
   assign l_press = L;
   assign r_press = R;
`endif

   // A right press drags the light in from the left neighbour, a left press from the right one
   assign pull_in  = (NL & r_press & ~l_press) | (NR & l_press & ~r_press);
   assign push_out = l_press ^ r_press;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= RST_STATE;
         lightOn <= (RST_STATE == ON);
      end else begin
         case (state)
            OFF: begin
               if (pull_in) begin
                  state   <= ON;
                  lightOn <= 1'b1;
               end
            end
            ON: begin
               if (push_out) begin
                  state   <= OFF;
                  lightOn <= 1'b0;
               end
            end
            default: begin
               state   <= RST_STATE;
               lightOn <= (RST_STATE == ON);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_center_light.sv
// tb/tb_center_light.sv - scoreboard bench for center_light, centre and normal instances side by side.
`timescale 1ns/1ps
module tb_center_light;

`ifdef CENTER_LIGHT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic L = 1'b0, R = 1'b0, NL = 1'b0, NR = 1'b0;
   logic on_c, on_n;

   int vectors = 0;
   int miscompares = 0;

   logic mc, mn;
   logic [1:0] exp_q[$];

   center_light #(.IS_CENTER(1'b1)) dut_c (
      .clk(clk), .reset(reset), .L(L), .R(R), .NL(NL), .NR(NR), .lightOn(on_c)
   );
   center_light #(.IS_CENTER(1'b0)) dut_n (
      .clk(clk), .reset(reset), .L(L), .R(R), .NL(NL), .NR(NR), .lightOn(on_n)
   );

   always #5 clk = ~clk;

   function automatic logic model_next(input logic s, input logic l, input logic r,
                                       input logic nl, input logic nr);
      if (s) return !(l ^ r);
      return (nl & r & ~l) | (nr & l & ~r);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      L = 1'b0; R = 1'b0; NL = 1'b0; NR = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      mc = 1'b1;
      mn = 1'b0;
      exp_q.delete();
   endtask

   // One-cycle press with neighbours held until the result is due; returns at the sampling negedge
   task automatic drive_press(input logic l, input logic r, input logic nl, input logic nr);
      @(negedge clk);
      L = l; R = r; NL = nl; NR = nr;
      mc = model_next(mc, l, r, nl, nr);
      mn = model_next(mn, l, r, nl, nr);
      exp_q.push_back({mc, mn});
      @(negedge clk);
      L = 1'b0; R = 1'b0;
      repeat (LAT - 1) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [1:0] e;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(2'b10);
         @(negedge clk);
         e = exp_q.pop_front();
         vectors++;
         if ({on_c, on_n} !== e) begin
            miscompares++;
            $display("FAIL reset_hold cyc%0d: got c=%b n=%b want c=%b n=%b", i, on_c, on_n, e[1], e[0]);
         end
      end
      reset = 1'b1;
      mc = 1'b1;
      mn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({mc, mn});
         @(negedge clk);
         e = exp_q.pop_front();
         vectors++;
         if ({on_c, on_n} !== e) begin
            miscompares++;
            $display("FAIL idle cyc%0d: got c=%b n=%b want c=%b n=%b", i, on_c, on_n, e[1], e[0]);
         end
      end
   endtask

   task automatic test_move_away();
      logic [3:0] tbl[2];
      logic [1:0] e;
      tbl[0] = 4'b1000;
      tbl[1] = 4'b1001;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive_press(tbl[i][3], tbl[i][2], tbl[i][1], tbl[i][0]);
         e = exp_q.pop_front();
         vectors++;
         if ({on_c, on_n} !== e) begin
            miscompares++;
            $display("FAIL move_away step%0d: got c=%b n=%b want c=%b n=%b", i, on_c, on_n, e[1], e[0]);
         end
      end
   endtask

   task automatic test_pull_in();
      logic [3:0] tbl[2];
      logic [1:0] e;
      tbl[0] = 4'b0110;
      tbl[1] = 4'b0100;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive_press(tbl[i][3], tbl[i][2], tbl[i][1], tbl[i][0]);
         e = exp_q.pop_front();
         vectors++;
         if ({on_c, on_n} !== e) begin
            miscompares++;
            $display("FAIL pull_in step%0d: got c=%b n=%b want c=%b n=%b", i, on_c, on_n, e[1], e[0]);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] tbl[4];
      logic [1:0] e;
      do_reset();
      // Both buttons held 3 cycles with both neighbours lit: ON and OFF instances both hold
      @(negedge clk);
      L = 1'b1; R = 1'b1; NL = 1'b1; NR = 1'b1;
      for (int i = 0; i < 3 + LAT; i++) begin
         if (i == 3) begin
            L = 1'b0; R = 1'b0;
         end
         exp_q.push_back({mc, mn});
         @(negedge clk);
         e = exp_q.pop_front();
         vectors++;
         if ({on_c, on_n} !== e) begin
            miscompares++;
            $display("FAIL both_pressed cyc%0d: got c=%b n=%b want c=%b n=%b", i, on_c, on_n, e[1], e[0]);
         end
      end
      NL = 1'b0; NR = 1'b0;
      // Wrong-direction presses keep dark lights dark; illegal NL=NR=1 still obeys the single-press rule
      tbl[0] = 4'b1010;
      tbl[1] = 4'b0101;
      tbl[2] = 4'b1011;
      tbl[3] = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         drive_press(tbl[i][3], tbl[i][2], tbl[i][1], tbl[i][0]);
         e = exp_q.pop_front();
         vectors++;
         if ({on_c, on_n} !== e) begin
            miscompares++;
            $display("FAIL direction step%0d: got c=%b n=%b want c=%b n=%b", i, on_c, on_n, e[1], e[0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] e;
      do_reset();
      drive_press(1'b1, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      vectors++;
      if ({on_c, on_n} !== e) begin
         miscompares++;
         $display("FAIL mid_setup: got c=%b n=%b want c=%b n=%b", on_c, on_n, e[1], e[0]);
      end
      #2;
      reset = 1'b0;
      L = 1'b1;
      NR = 1'b1;
      exp_q.push_back(2'b10);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if ({on_c, on_n} !== e) begin
         miscompares++;
         $display("FAIL async_reset: got c=%b n=%b want c=%b n=%b", on_c, on_n, e[1], e[0]);
      end
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(2'b10);
         @(negedge clk);
         e = exp_q.pop_front();
         vectors++;
         if ({on_c, on_n} !== e) begin
            miscompares++;
            $display("FAIL reset_press_held cyc%0d: got c=%b n=%b want c=%b n=%b", i, on_c, on_n, e[1], e[0]);
         end
      end
      reset = 1'b1;
      L = 1'b0;
      NR = 1'b0;
      mc = 1'b1;
      mn = 1'b0;
      for (int i = 0; i < LAT + 1; i++) begin
         exp_q.push_back({mc, mn});
         @(negedge clk);
         e = exp_q.pop_front();
         vectors++;
         if ({on_c, on_n} !== e) begin
            miscompares++;
            $display("FAIL after_release cyc%0d: got c=%b n=%b want c=%b n=%b", i, on_c, on_n, e[1], e[0]);
         end
      end
   endtask

`ifdef CENTER_LIGHT_SYNC_EN
   task automatic test_level_hold();
      logic [1:0] e;
      do_reset();
      // L held 5 cycles must act once: centre goes dark and stays dark, normal light gets lit once
      @(negedge clk);
      L = 1'b1; NR = 1'b1;
      mc = 1'b0;
      mn = 1'b1;
      repeat (5) @(negedge clk);
      L = 1'b0;
      repeat (LAT) @(negedge clk);
      exp_q.push_back({mc, mn});
      e = exp_q.pop_front();
      vectors++;
      if ({on_c, on_n} !== e) begin
         miscompares++;
         $display("FAIL level_hold: got c=%b n=%b want c=%b n=%b", on_c, on_n, e[1], e[0]);
      end
      NR = 1'b0;
   endtask
`endif

   initial begin
      mc = 1'b1;
      mn = 1'b0;
      test_reset();
      test_move_away();
      test_pull_in();
      test_simultaneous();
      test_reset_mid();
`ifdef CENTER_LIGHT_SYNC_EN
      test_level_hold();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
